// File: rtl/alarm_buzzer_sequencer.sv
// Alarm ring sequencer: gated tone with on/off beep cadence, auto-timeout,
// limited snoozes and a lockout that holds off retrigger while the time still matches.
module alarm_buzzer_sequencer #(
  parameter int CLK_HZ         = 31500000,
  parameter int TONE_HZ        = 3150,
  parameter int BEEP_TICKS     = 50,
  parameter int RING_TIMEOUT_S = 60,
  parameter int SNOOZE_S       = 300,
  parameter int MAX_SNOOZES    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_100hz,
  input  logic       alarm_match,
  input  logic       alarm_enable,
  input  logic       stop_pulse,
  input  logic       snooze_pulse,
  output logic       buzzer_out,
  output logic       ringing,
  output logic       snoozing,
  output logic [1:0] snooze_count
);

  localparam int HALF_PERIOD  = CLK_HZ / (2 * TONE_HZ);
  localparam int RING_TICKS   = RING_TIMEOUT_S * 100;
  localparam int SNOOZE_TICKS = SNOOZE_S * 100;
  localparam int MAX_TICKS    = (RING_TICKS > SNOOZE_TICKS) ? RING_TICKS : SNOOZE_TICKS;
  localparam int TICK_W       = $clog2(MAX_TICKS + 1);
  localparam int BEEP_W       = $clog2(BEEP_TICKS + 1);
  localparam int HALF_W       = $clog2(HALF_PERIOD + 1);

  localparam logic [TICK_W-1:0] RING_LAST   = TICK_W'(RING_TICKS - 1);
  localparam logic [TICK_W-1:0] SNOOZE_LAST = TICK_W'(SNOOZE_TICKS - 1);
  localparam logic [BEEP_W-1:0] BEEP_LAST   = BEEP_W'(BEEP_TICKS - 1);
  localparam logic [HALF_W-1:0] HALF_LAST   = HALF_W'(HALF_PERIOD - 1);
  localparam logic [1:0]        MAX_SN      = 2'(MAX_SNOOZES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RINGING,
    ST_SNOOZE,
    ST_LOCKOUT
  } state_t;

  state_t            state_q, state_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [BEEP_W-1:0] beep_q, beep_d;
  logic [HALF_W-1:0] half_q, half_d;
  logic              phase_q, phase_d;
  logic              tone_q, tone_d;
  logic [1:0]        snz_cnt_q, snz_cnt_d;
  logic              buzzer_q, buzzer_d;
  logic              ring_q, ring_d;
  logic              snoozing_q, snoozing_d;

  logic ring_expire, snooze_expire, ring_run;

  // Expiry fires on the tick that completes the interval, so the exit edge
  // coincides with the last counted tick.
  assign ring_expire   = tick_100hz && (tick_q >= RING_LAST);
  assign snooze_expire = tick_100hz && (tick_q >= SNOOZE_LAST);

  always_comb begin
    state_d   = state_q;
    snz_cnt_d = snz_cnt_q;
    if (!alarm_enable) begin
      state_d   = ST_IDLE;
      snz_cnt_d = 2'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (alarm_match) state_d = ST_RINGING;
        end
        ST_RINGING: begin
          if (stop_pulse) begin
            state_d = ST_LOCKOUT;
          end else if (snooze_pulse) begin
            if (snz_cnt_q < MAX_SN) begin
              state_d   = ST_SNOOZE;
              snz_cnt_d = snz_cnt_q + 2'd1;
            end else begin
              state_d = ST_LOCKOUT;
            end
          end else if (ring_expire) begin
            state_d = ST_LOCKOUT;
          end
        end
        ST_SNOOZE: begin
          if (stop_pulse)         state_d = ST_LOCKOUT;
          else if (snooze_expire) state_d = ST_RINGING;
        end
        ST_LOCKOUT: begin
          if (!alarm_match) begin
            state_d   = ST_IDLE;
            snz_cnt_d = 2'd0;
          end
        end
        default: begin
          state_d   = ST_IDLE;
          snz_cnt_d = 2'd0;
        end
      endcase
    end
  end

  // Every state entry restarts the tick count; within a state it saturates.
  assign ring_run = (state_q == ST_RINGING) && (state_d == ST_RINGING);

  always_comb begin
    tick_d = tick_q;
    if (state_d != state_q)                  tick_d = '0;
    else if (tick_100hz && (tick_q != '1))   tick_d = tick_q + 1'b1;
  end

  always_comb begin
    beep_d  = beep_q;
    phase_d = phase_q;
    half_d  = half_q;
    tone_d  = tone_q;
    if (!ring_run) begin
      beep_d  = '0;
      phase_d = 1'b1;
      half_d  = '0;
      tone_d  = 1'b0;
    end else begin
      if (tick_100hz) begin
        if (beep_q == BEEP_LAST) begin
          beep_d  = '0;
          phase_d = ~phase_q;
        end else begin
          beep_d = beep_q + 1'b1;
        end
      end
      if (half_q == HALF_LAST) begin
        half_d = '0;
        tone_d = ~tone_q;
      end else begin
        half_d = half_q + 1'b1;
      end
    end
  end

  // Outputs are registered from next-state values so they line up with state_q.
  always_comb begin
    ring_d     = (state_d == ST_RINGING);
    snoozing_d = (state_d == ST_SNOOZE);
    buzzer_d   = ring_d && phase_d && tone_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      tick_q     <= '0;
      beep_q     <= '0;
      half_q     <= '0;
      phase_q    <= 1'b1;
      tone_q     <= 1'b0;
      snz_cnt_q  <= 2'd0;
      buzzer_q   <= 1'b0;
      ring_q     <= 1'b0;
      snoozing_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      beep_q     <= beep_d;
      half_q     <= half_d;
      phase_q    <= phase_d;
      tone_q     <= tone_d;
      snz_cnt_q  <= snz_cnt_d;
      buzzer_q   <= buzzer_d;
      ring_q     <= ring_d;
      snoozing_q <= snoozing_d;
    end
  end

  assign buzzer_out   = buzzer_q;
  assign ringing      = ring_q;
  assign snoozing     = snoozing_q;
  assign snooze_count = snz_cnt_q;

endmodule

// File: tb/tb_alarm_buzzer_sequencer.sv
// Self-checking bench for alarm_buzzer_sequencer using scaled-down timing parameters.
module tb_alarm_buzzer_sequencer;

  localparam int CLK_HZ         = 100;
  localparam int TONE_HZ        = 10;
  localparam int HALF           = CLK_HZ / (2 * TONE_HZ);
  localparam int BEEP           = 4;
  localparam int RING_TIMEOUT_S = 1;
  localparam int SNOOZE_S       = 2;
  localparam int RING_TICKS     = RING_TIMEOUT_S * 100;
  localparam int SNOOZE_TICKS   = SNOOZE_S * 100;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick_100hz, alarm_match, alarm_enable, stop_pulse, snooze_pulse;
  logic       buzzer_out, ringing, snoozing;
  logic [1:0] snooze_count;

  always #5 clk = ~clk;

  alarm_buzzer_sequencer #(
    .CLK_HZ(CLK_HZ), .TONE_HZ(TONE_HZ), .BEEP_TICKS(BEEP),
    .RING_TIMEOUT_S(RING_TIMEOUT_S), .SNOOZE_S(SNOOZE_S), .MAX_SNOOZES(3)
  ) dut (
    .clk(clk), .reset(reset), .tick_100hz(tick_100hz),
    .alarm_match(alarm_match), .alarm_enable(alarm_enable),
    .stop_pulse(stop_pulse), .snooze_pulse(snooze_pulse),
    .buzzer_out(buzzer_out), .ringing(ringing), .snoozing(snoozing),
    .snooze_count(snooze_count)
  );

  // Expected outputs {ringing, snoozing, snooze_count, buzzer_out}.
  typedef struct packed {
    logic       ring;
    logic       snz;
    logic [1:0] cnt;
    logic       buz;
  } exp_t;

  // Stimulus {enable, match, stop, snooze, tick}.
  typedef struct packed {
    logic [4:0] stim;
    exp_t       e;
  } vec_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;

  function automatic exp_t ex(input logic r, input logic s, input logic [1:0] c, input logic b);
    exp_t t;
    t.ring = r;
    t.snz  = s;
    t.cnt  = c;
    t.buz  = b;
    return t;
  endfunction

  task automatic check1(input string name, input logic [1:0] act, input logic [1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag, input exp_t x);
    check1({tag, ".ringing"},  {1'b0, ringing},    {1'b0, x.ring});
    check1({tag, ".snoozing"}, {1'b0, snoozing},   {1'b0, x.snz});
    check1({tag, ".count"},    snooze_count,       x.cnt);
    check1({tag, ".buzzer"},   {1'b0, buzzer_out}, {1'b0, x.buz});
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic step(input logic [4:0] stim, input exp_t x, input string tag);
    exp_t got;
    {alarm_enable, alarm_match, stop_pulse, snooze_pulse, tick_100hz} = stim;
    sb_q.push_back(x);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      got = sb_q.pop_front();
      check_outputs(tag, got);
    end
  endtask

  // k counts edges after the RINGING entry edge; ticks (if enabled) on every cycle.
  task automatic ring_check(input int n, input logic tk, input logic [1:0] c);
    logic ph, rg, tn;
    for (int k = 1; k <= n; k++) begin
      ph = tk ? (((k / BEEP) % 2) == 0) : 1'b1;
      rg = tk ? (k < RING_TICKS) : 1'b1;
      tn = ((k / HALF) % 2) == 1;
      step({4'b1100, tk}, ex(rg, 1'b0, c, rg & ph & tn), $sformatf("ring_k%0d", k));
    end
  endtask

  task automatic snooze_wait(input logic [1:0] c);
    logic done;
    for (int s = 1; s <= SNOOZE_TICKS; s++) begin
      done = (s >= SNOOZE_TICKS);
      step(5'b10001, ex(done, ~done, c, 1'b0), $sformatf("snooze%0d_s%0d", c, s));
    end
  endtask

  vec_t tbl[17];

  initial begin
    tbl[0]  = {5'b10000, 5'b00000};  // idle, no match
    tbl[1]  = {5'b01001, 5'b00000};  // match without enable
    tbl[2]  = {5'b11001, 5'b10000};  // arm
    tbl[3]  = {5'b11110, 5'b00000};  // stop+snooze together -> lockout
    tbl[4]  = {5'b11001, 5'b00000};  // lockout holds while matching
    tbl[5]  = {5'b10000, 5'b00000};  // match drops -> idle
    tbl[6]  = {5'b11000, 5'b10000};  // ring
    tbl[7]  = {5'b11010, 5'b01010};  // snooze 1
    tbl[8]  = {5'b11010, 5'b01010};  // snooze ignored while snoozing
    tbl[9]  = {5'b01000, 5'b00000};  // disable mid-snooze
    tbl[10] = {5'b11000, 5'b10000};  // ring
    tbl[11] = {5'b10011, 5'b01010};  // snooze 1
    tbl[12] = {5'b11100, 5'b00010};  // stop in snooze -> lockout, count kept
    tbl[13] = {5'b10000, 5'b00000};  // release -> idle, count cleared
    tbl[14] = {5'b11000, 5'b10000};  // ring
    tbl[15] = {5'b01000, 5'b00000};  // disable mid-ring
    tbl[16] = {5'b10000, 5'b00000};  // idle

    reset = 1'b1;
    {alarm_enable, alarm_match, stop_pulse, snooze_pulse, tick_100hz} = 5'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset", ex(1'b0, 1'b0, 2'd0, 1'b0));
    reset = 1'b0;

    for (int i = 0; i < 17; i++)
      step(tbl[i].stim, tbl[i].e, $sformatf("vec%0d", i));

    // Arm, cadence with continuous ticks, timeout into lockout, release and re-arm.
    step(5'b11000, ex(1'b1, 1'b0, 2'd0, 1'b0), "arm");
    ring_check(RING_TICKS + 3, 1'b1, 2'd0);
    step(5'b10000, ex(1'b0, 1'b0, 2'd0, 1'b0), "unlock");
    step(5'b11000, ex(1'b1, 1'b0, 2'd0, 1'b0), "rearm");

    // Three snoozes with re-entry restart, then the fourth acts as stop.
    ring_check(10, 1'b1, 2'd0);
    for (int n = 1; n <= 3; n++) begin
      step(5'b11011, ex(1'b0, 1'b1, 2'(n), 1'b0), $sformatf("snooze_req%0d", n));
      snooze_wait(2'(n));
      ring_check(12, 1'b1, 2'(n));
    end
    step(5'b11010, ex(1'b0, 1'b0, 2'd3, 1'b0), "snooze4");
    step(5'b11000, ex(1'b0, 1'b0, 2'd3, 1'b0), "lock_hold");
    step(5'b10000, ex(1'b0, 1'b0, 2'd0, 1'b0), "release");

    // Async reset between edges while the buzzer is high.
    step(5'b11000, ex(1'b1, 1'b0, 2'd0, 1'b0), "arm2");
    ring_check(6, 1'b0, 2'd0);
    #3 reset = 1'b1;
    #1 check_outputs("async_rst", ex(1'b0, 1'b0, 2'd0, 1'b0));
    #2 reset = 1'b0;
    step(5'b10000, ex(1'b0, 1'b0, 2'd0, 1'b0), "post_rst");
    step(5'b11000, ex(1'b1, 1'b0, 2'd0, 1'b0), "rearm3");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
